// File: rtl/int_freelist.sv
// int_freelist: physical integer register free list feeding rename.
// Circular buffer with speculative head, committed head and tail; squash rewinds the speculative head.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

module int_freelist #(
    parameter int unsigned SIZE        = 80,
    parameter int unsigned ARCH_NUM    = 32,
    parameter int unsigned ALLOC_WIDTH = `RENAME_WIDTH,
    parameter int unsigned FREE_WIDTH  = `COMMIT_WIDTH,
    localparam int unsigned IDX_W      = $clog2(SIZE),
    localparam int unsigned CMT_W      = $clog2(FREE_WIDTH + 1),
    localparam int unsigned CNT_W      = $clog2(SIZE + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_alloc_vld,
    input  logic [ALLOC_WIDTH-1:0]            i_alloc_mask,
    output logic                              o_alloc_rdy,
    output logic [ALLOC_WIDTH-1:0][IDX_W-1:0] o_alloc_iprIdx,
    input  logic [CMT_W-1:0]                  i_commit_alloc_cnt,
    input  logic [FREE_WIDTH-1:0]             i_free_vld,
    input  logic [FREE_WIDTH-1:0][IDX_W-1:0]  i_free_iprIdx,
    input  logic                              i_squash,
    output logic [CNT_W-1:0]                  o_free_cnt
);
    localparam int unsigned   DEPTH   = SIZE - ARCH_NUM;
    localparam int unsigned   PI_W    = $clog2(DEPTH);
    localparam logic [PI_W:0] DEPTH_N = (PI_W + 1)'(DEPTH);
    localparam logic [PI_W:0] ONE_N   = (PI_W + 1)'(1);

    typedef struct packed {
        logic            wrap;
        logic [PI_W-1:0] idx;
    } ptr_t;

    // idx wraps at DEPTH (not a power of two), so the wrap bit is toggled explicitly
    function automatic ptr_t ptr_add(input ptr_t p, input logic [PI_W:0] n);
        ptr_t          r;
        logic [PI_W:0] sum;
        sum = {1'b0, p.idx} + n;
        if (sum >= DEPTH_N) begin
            r.idx  = PI_W'(sum - DEPTH_N);
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = sum[PI_W-1:0];
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] ptr_cnt(input ptr_t a, input ptr_t b);
        logic [PI_W:0] d;
        if (a.wrap == b.wrap) d = {1'b0, b.idx} - {1'b0, a.idx};
        else                  d = DEPTH_N - {1'b0, a.idx} + {1'b0, b.idx};
        return CNT_W'(d);
    endfunction

    ptr_t                            spec_head;
    ptr_t                            commit_head;
    ptr_t                            tail;
    ptr_t                            commit_nxt;
    logic [IDX_W-1:0]                entry [DEPTH];
    logic [PI_W:0]                   alloc_n;
    logic [PI_W:0]                   free_n;
    logic                            alloc_fire;
    logic [FREE_WIDTH-1:0]           wr_en;
    logic [FREE_WIDTH-1:0][PI_W-1:0] wr_idx;

    always_comb begin
        ptr_t rd;
        alloc_n        = '0;
        rd             = spec_head;
        o_alloc_iprIdx = '0;
        for (int unsigned k = 0; k < ALLOC_WIDTH; k++) begin
            rd                = ptr_add(spec_head, alloc_n);
            o_alloc_iprIdx[k] = entry[rd.idx];
            if (i_alloc_mask[k]) alloc_n = alloc_n + ONE_N;
        end
    end

    assign o_free_cnt  = ptr_cnt(spec_head, tail);
    assign o_alloc_rdy = (o_free_cnt >= CNT_W'(alloc_n)) && !i_squash;
    assign alloc_fire  = i_alloc_vld && o_alloc_rdy;
    assign commit_nxt  = ptr_add(commit_head, (PI_W + 1)'(i_commit_alloc_cnt));

    // Valid non-zero frees are packed in port order starting at tail
    always_comb begin
        ptr_t wp;
        free_n = '0;
        wr_en  = '0;
        wr_idx = '0;
        wp     = tail;
        for (int unsigned j = 0; j < FREE_WIDTH; j++) begin
            wp        = ptr_add(tail, free_n);
            wr_idx[j] = wp.idx;
            if (i_free_vld[j] && (i_free_iprIdx[j] != '0)) begin
                wr_en[j] = 1'b1;
                free_n   = free_n + ONE_N;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail.wrap   <= 1'b1;
            tail.idx    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry[PI_W'(i)] <= IDX_W'(ARCH_NUM + i);
            end
        end else begin
            commit_head <= commit_nxt;
            tail        <= ptr_add(tail, free_n);
            if (i_squash) begin
                spec_head <= commit_nxt;
            end else if (alloc_fire) begin
                spec_head <= ptr_add(spec_head, alloc_n);
            end
            for (int unsigned j = 0; j < FREE_WIDTH; j++) begin
                if (wr_en[j]) entry[wr_idx[j]] <= i_free_iprIdx[j];
            end
        end
    end

    a_commit_overrun: assert property (@(posedge clk) disable iff (rst)
        ptr_cnt(commit_head, spec_head) >= CNT_W'(i_commit_alloc_cnt));

    // Same-cycle commit retires the allocations whose stale regs are being freed
    a_free_overflow: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, ptr_cnt(commit_nxt, tail)} + (CNT_W + 1)'(free_n)) <= (CNT_W + 1)'(DEPTH));

endmodule
